stack_arbiter: RTL
==================

Name: stack_arbiter

Overview:
- Shares one LIFO stack between NREQ independent requesters using round-robin arbitration.
- Sequences each accepted request as exactly one push or pop strobe on the stack port.
- Returns pop data, or an error, to the requester that issued it.
- Sits between client engines and a single stack instance. Prevents double strobes, pushes when the stack is full and pops when it is empty.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 32, data word width.
- IDXW, $clog2(NREQ), requester index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request pending.
- req_op  input  NREQ  per-requester op: 0 = push, 1 = pop.
- req_wdata  input  NREQ*WIDTH  push data; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot accept strobe.
- resp_valid  output  NREQ  one-hot completion strobe.
- resp_err  output  1  completion failed (push when full, or pop when empty).
- resp_data  output  WIDTH  popped word; 0 for a push or an error.
- busy  output  1  high when the FSM is not IDLE.
- stk_push  output  1  stack push strobe.
- stk_pop  output  1  stack pop strobe.
- stk_wdata  output  WIDTH  stack write data.
- stk_rdata  input  WIDTH  stack top-of-stack word (combinational from the stack).
- stk_empty  input  1  stack empty flag.
- stk_full  input  1  stack full flag.

Behaviour:
- Reset, asynchronous: applies immediately, regardless of clock.
  - FSM goes to IDLE; rr_ptr = 0.
  - All latched fields (idx, op, wdata, data, err) = 0.
  - req_ready, resp_valid, resp_err, resp_data, stk_push, stk_pop, stk_wdata, busy all 0.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. Each state lasts exactly one cycle, except IDLE, which waits for a request.
- IDLE:
  - The winner is the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner] is asserted combinationally in this cycle only.
  - At the clock edge, latch idx = winner, op = req_op[winner], wdata = req_wdata[winner] slice, then go to ISSUE.
  - With no req_valid, stay in IDLE.
- ISSUE:
  - Push: if stk_full = 0, assert stk_push and drive stk_wdata = wdata. Otherwise assert no strobe and latch err = 1.
  - Pop: if stk_empty = 0, assert stk_pop and latch data = stk_rdata at the edge. Otherwise assert no strobe and latch err = 1.
  - Strobes are combinational from the state and last exactly one cycle. stk_push and stk_pop are never asserted together.
- RESP:
  - resp_valid[idx] = 1 for one cycle.
  - resp_err = err; resp_data = data for a successful pop, else 0.
  - At the edge: rr_ptr = (idx + 1) mod NREQ, clear the latches, return to IDLE.
- Latency: accept -> strobe = 1 cycle; accept -> response = 2 cycles. Throughput is 1 op per 3 cycles.
  - The gap guarantees stk_full and stk_empty have settled after the previous strobe.
- Requester rules:
  - Hold req_valid, req_op and req_wdata stable until req_ready is seen.
  - Dropping req_valid before req_ready is permitted; that request is simply not served.
  - A requester may reassert req_valid in the RESP cycle. It is eligible again in the next IDLE, but rr_ptr puts it last in the search.
- Simultaneous requests: exactly one grant per IDLE cycle. With all NREQ requesting continuously, grants rotate 0,1,2,3,0,...
- Boundary conditions:
  - A push when full or a pop when empty never strobes the stack.
  - An erroneous completion still advances rr_ptr.
- Reset mid-operation: an in-flight request is dropped without a response, and any strobe deasserts immediately.
  - The stack keeps its own state; the arbiter does not reset it.

Test Plan:
- Single push then pop: requester 2 pushes 0xDEADBEEF, then pops.
  - Expect req_ready=0b0100, then one cycle later stk_push=1 with stk_wdata=0xDEADBEEF, then resp_valid=0b0100 with resp_err=0.
  - The later pop returns resp_data=0xDEADBEEF, resp_err=0.
- Round robin: all 4 requesters hold push requests of values 1..4 from reset.
  - Expect grant order 0,1,2,3 at accept cycles t, t+3, t+6, t+9.
  - Each stk_push is a single cycle, followed by 4 pops.
  - The pops return 4, 3, 2, 1.
- Empty pop: with the stack empty, requester 1 pops.
  - Expect no stk_pop, then resp_valid=0b0010 with resp_err=1, resp_data=0.
- Full push: drive stk_full=1 and have requester 3 push 0x55.
  - Expect no stk_push, then resp_err=1.
  - rr_ptr advances to 0, so the next grant with requesters 0 and 3 both valid goes to 0.
- Reset mid-operation: assert rst asynchronously (mid-cycle) while in ISSUE with stk_pop high.
  - Expect stk_pop, busy and resp_valid at 0 immediately, and no response after release.
  - After release, the first grant goes to the lowest valid index.
- Withdrawn request: requester 0 drops req_valid before any grant while requester 1 holds.
  - Expect the grant to go to requester 1 and nothing issued for requester 0.

Source files
------------

// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//
// Purpose:
//   Shares one LIFO stack between NREQ requesters. A round-robin search picks
//   one requester per IDLE cycle. The accepted request becomes a single push
//   or pop strobe on the stack port. The completion, which carries the popped
//   data or an error, goes back to the requester that issued the request.
//   Every operation takes three cycles: IDLE (accept), ISSUE (strobe) and
//   RESP (completion). This gap lets the stack's full/empty flags settle
//   before the next operation looks at them.
//
// Parameters:
//   NREQ   number of requesters (2..16)
//   WIDTH  data word width
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req_valid      per-requester request pending
//   req_op         per-requester op, 0 = push, 1 = pop
//   req_wdata      packed push data, requester i at [i*WIDTH +: WIDTH]
//   req_ready      one-hot accept strobe (combinational, IDLE only)
//   resp_valid     one-hot completion strobe (RESP only)
//   resp_err       completion failed (push when full / pop when empty)
//   resp_data      popped word, 0 for a push or an error
//   busy           FSM is not IDLE
//   stk_push       stack push strobe
//   stk_pop        stack pop strobe
//   stk_wdata      stack write data
//   stk_rdata      stack top-of-stack word
//   stk_empty      stack empty flag
//   stk_full       stack full flag
// -----------------------------------------------------------------------------
module stack_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic                  resp_err,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  busy,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH-1:0]      stk_wdata,
  input  logic [WIDTH-1:0]      stk_rdata,
  input  logic                  stk_empty,
  input  logic                  stk_full
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and latched request fields
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic [IDXW-1:0]   rr_ptr_q;
  logic [IDXW-1:0]   idx_q;
  logic              op_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  data_q;
  logic              err_q;

  logic [IDXW-1:0]   rr_ptr_d;
  logic [IDXW-1:0]   grant_idx;
  logic              grant_found;

  // Unpacked view of the packed write-data bus.
  logic [WIDTH-1:0]  req_wdata_arr [NREQ];

  // (base + off) mod NREQ. Both operands are below NREQ, so one conditional
  // subtraction is enough. The extra bit keeps the sum from wrapping early.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input int unsigned     off);
    logic [IDXW:0] sum;
    sum = {1'b0, base} + (IDXW+1)'(off);
    if (sum >= (IDXW+1)'(NREQ)) begin
      sum = sum - (IDXW+1)'(NREQ);
    end
    return sum[IDXW-1:0];
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_wdata
    assign req_wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: the first valid requester starting at rr_ptr_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [IDXW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // After a completion, the requester just served goes to the back of the line.
  assign rr_ptr_d = wrap_add(idx_q, 1);

  // ---------------------------------------------------------------------------
  // One-hot accept and completion strobes
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign req_ready[gi]  = (state_q == IDLE) && grant_found && (grant_idx == IDXW'(gi));
    assign resp_valid[gi] = (state_q == RESP) && (idx_q == IDXW'(gi));
  end

  // ---------------------------------------------------------------------------
  // Stack strobes. These are decoded straight from the state, so an
  // asynchronous reset removes them at once. A push while full or a pop while
  // empty never reaches the stack.
  // ---------------------------------------------------------------------------
  assign stk_push  = (state_q == ISSUE) && !op_q && !stk_full;
  assign stk_pop   = (state_q == ISSUE) &&  op_q && !stk_empty;
  assign stk_wdata = stk_push ? wdata_q : '0;

  // data_q is written only by a successful pop, so it is already zero for a
  // push or for an error.
  assign resp_err  = (state_q == RESP) && err_q;
  assign resp_data = (state_q == RESP) ? data_q : '0;
  assign busy      = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      op_q     <= 1'b0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            idx_q   <= grant_idx;
            op_q    <= req_op[grant_idx];
            wdata_q <= req_wdata_arr[grant_idx];
            state_q <= ISSUE;
          end
        end

        ISSUE: begin
          if (op_q) begin
            // Capture top-of-stack on the same edge that pops it.
            if (!stk_empty) data_q <= stk_rdata;
            else            err_q  <= 1'b1;
          end else if (stk_full) begin
            err_q <= 1'b1;
          end
          state_q <= RESP;
        end

        RESP: begin
          rr_ptr_q <= rr_ptr_d;
          idx_q    <= '0;
          op_q     <= 1'b0;
          wdata_q  <= '0;
          data_q   <= '0;
          err_q    <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
